// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 memory slave with registered feedback: classic cycles plus
// incrementing bursts (linear, wrap-4/8/16), byte-lane writes and range error.
module wb_burst_mem_slave #(
  parameter int          DEPTH    = 8192,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int WORDS = DEPTH / 4;
  localparam int AW    = $clog2(WORDS);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [31:0]     dat_q, dat_d;
  logic [AW-1:0]   baddr_q, baddr_d;

  logic [31:0]     mem [WORDS];

  logic [31:0]     offset;
  logic [AW-1:0]   off;
  logic [AW-1:0]   nxt;
  logic            in_range;
  logic            req;
  logic            wr_en;

  // Wrap bursts keep the upper bits and roll only the low log2(N) bits;
  // linear uses an all-ones mask so it wraps at the top of memory.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic [1:0]    bte);
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    inc = a + AW'(1);
    case (bte)
      2'b01:   mask = AW'(3);
      2'b10:   mask = AW'(7);
      2'b11:   mask = AW'(15);
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  assign offset   = wb_adr_i - MEM_BASE;
  assign in_range = offset < 32'(DEPTH);
  assign off      = offset[AW+1:2];
  assign nxt      = next_addr(baddr_q, wb_bte_i);
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign wr_en    = ack_q & wb_we_i & wb_cyc_i & wb_stb_i & ~wb_rst_i;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    baddr_d = baddr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (in_range) begin
            ack_d   = 1'b1;
            dat_d   = mem[off];
            baddr_d = off;
            if (wb_cti_i == 3'b010) state_d = BURST;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BURST: begin
        if (ack_q && wb_cyc_i && wb_stb_i && wb_cti_i == 3'b010) begin
          ack_d   = 1'b1;
          baddr_d = nxt;
          dat_d   = mem[nxt];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      baddr_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      baddr_q <= baddr_d;
    end
  end

  // NOTE: the memory array is deliberately not reset; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[baddr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed self-checking bench for wb_burst_mem_slave: classic, byte-lane,
// linear and wrap bursts, out-of-range error, aborted burst and reset.
module tb_wb_burst_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] rdat;
  logic        ack;
  logic        err;
  logic        rty;

  int checks = 0;
  int errors = 0;

  wb_burst_mem_slave dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_dat_o (rdat),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  // One classic access; ack (or err) must appear one cycle after stb and
  // drop on the following cycle.
  task automatic classic(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic exp_err, input logic chk_dat,
                         input logic [31:0] exp_dat);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    cti = 3'b000; bte = 2'b00;
    tick();
    check({tag, "_ack"}, 32'(ack), 32'(!exp_err));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    if (chk_dat) check({tag, "_dat"}, rdat, exp_dat);
    tick();
    idle_bus();
    check({tag, "_ack_low"}, 32'(ack), 32'd0);
    check({tag, "_err_low"}, 32'(err), 32'd0);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    classic(tag, 1'b1, a, d, s, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    classic(tag, 1'b0, a, 32'd0, 4'hF, 1'b0, 1'b1, exp);
  endtask

  logic [31:0] wrap_data [4] = '{32'd1, 32'd2, 32'd3, 32'd4};

  initial begin
    rst = 1'b1; adr = '0; wdat = '0; sel = 4'hF;
    idle_bus();
    tick();
    tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rty", 32'(rty), 32'd0);
    rst = 1'b0;
    tick();

    // Classic write/read and byte-lane write.
    wr("wr_100", 32'h100, 32'hDEAD_BEEF, 4'hF);
    rd("rd_100", 32'h100, 32'hDEAD_BEEF);
    wr("wr_byte", 32'h100, 32'h0000_00AA, 4'b0001);
    rd("rd_byte", 32'h100, 32'hDEAD_BEAA);

    // Out-of-range accesses: err only, dat_o and memory untouched.
    wr("wr_0", 32'h0, 32'h1111_1111, 4'hF);
    rd("rd_100b", 32'h100, 32'hDEAD_BEAA);
    classic("oor_rd", 1'b0, 32'h2000, 32'd0, 4'hF, 1'b1, 1'b1, 32'hDEAD_BEAA);
    classic("oor_wr", 1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'd0);
    rd("oor_chk0", 32'h0, 32'h1111_1111);
    rd("oor_chk100", 32'h100, 32'hDEAD_BEAA);

    // Preload words 0x80..0x83 with their own word offset.
    for (int i = 0; i < 4; i++) wr("pre", 32'h200 + 32'(4 * i), 32'h80 + 32'(i), 4'hF);

    // Linear burst read of 4 beats; adr is scrambled after the first beat.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h200; cti = 3'b010; bte = 2'b00;
    tick();
    check("lin_b0_ack", 32'(ack), 32'd1);
    check("lin_b0_dat", rdat, 32'h80);
    adr = 32'h1F00;
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("lin_b%0d_ack", i), 32'(ack), 32'd1);
      check($sformatf("lin_b%0d_dat", i), rdat, 32'h80 + 32'(i));
    end
    cti = 3'b111;
    tick();
    check("lin_end_ack", 32'(ack), 32'd0);
    idle_bus();
    tick();
    check("lin_idle_ack", 32'(ack), 32'd0);

    // Wrap-4 burst write starting at 0x30C; 0x310 must stay untouched.
    wr("pre_310", 32'h310, 32'h55, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30C; sel = 4'hF;
    cti = 3'b010; bte = 2'b01; wdat = wrap_data[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_b%0d_ack", i), 32'(ack), 32'd1);
      wdat = wrap_data[i];
      if (i == 3) cti = 3'b111;
      tick();
    end
    check("wrap_end_ack", 32'(ack), 32'd0);
    idle_bus();
    tick();
    rd("wrap_30c", 32'h30C, 32'd1);
    rd("wrap_300", 32'h300, 32'd2);
    rd("wrap_304", 32'h304, 32'd3);
    rd("wrap_308", 32'h308, 32'd4);
    rd("wrap_310", 32'h310, 32'h55);

    // Linear burst with stb dropped after beat 2.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h200; cti = 3'b010; bte = 2'b00;
    tick();
    check("abort_b0_dat", rdat, 32'h80);
    tick();
    check("abort_b1_ack", 32'(ack), 32'd1);
    check("abort_b1_dat", rdat, 32'h81);
    stb = 1'b0;
    tick();
    check("abort_ack", 32'(ack), 32'd0);
    idle_bus();
    rd("abort_rd", 32'h20C, 32'h83);

    // Reset asserted during the first beat of a write burst: no write occurs.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h208; wdat = 32'h0BAD_0BAD;
    sel = 4'hF; cti = 3'b010; bte = 2'b00;
    tick();
    check("rstb_b0_ack", 32'(ack), 32'd1);
    rst = 1'b1;
    tick();
    check("rstb_ack", 32'(ack), 32'd0);
    check("rstb_dat", rdat, 32'd0);
    rst = 1'b0;
    idle_bus();
    tick();
    rd("rstb_rd208", 32'h208, 32'h82);
    rd("rstb_rd200", 32'h200, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
